fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction fetch stage for the 16-bit myMIPS core. It sits directly upstream of the control/decode block.
- Owns the program counter and drives a synchronous instruction ROM.
- Tracks ROM reads that are still in flight.
- Presents each fetched instruction to decode with a valid flag and its PC.
- Applies redirects (taken beq, j/jr/jal) and decode stalls without dropping or duplicating instructions.

Parameters:
ADDR_W, 12, PC / ROM address width; all PC arithmetic is modulo 2^ADDR_W
DATA_W, 16, instruction width
RESET_PC, 0, first fetch address after reset

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  asynchronous, active-low reset
ROM_addr  output  ADDR_W  ROM read address (registered)
rom_rd  output  1  ROM read enable (registered)
ROM_data  input  DATA_W  ROM read data; valid one cycle after the edge that sampled ROM_addr/rom_rd
PC_MUX  input  2  redirect select: 00/01 sequential, 10 branch, 11 jump
branch_taken  input  1  qualifies PC_MUX=10
redirect_pc  input  ADDR_W  PC of the redirecting instruction
branch_offset  input  6  signed word offset for beq
jump_addr  input  ADDR_W  absolute target for j/jr/jal
stall  input  1  decode cannot accept a new instruction
instr  output  DATA_W  fetched instruction (registered)
instr_valid  output  1  instr is a live, in-order instruction
instr_pc  output  ADDR_W  address of instr
link_pc  output  ADDR_W  instr_pc+1, used for jal

Behaviour:
- Reset (async, rst=0):
  - pc=RESET_PC, ROM_addr=RESET_PC, rom_rd=0.
  - instr=0, instr_valid=0, instr_pc=0, link_pc=1.
  - In-flight tags cleared; state=BOOT.
- Pipeline: two tag stages (t1 = address sampled by ROM, t2 = data on ROM_data), each holding {valid, addr}.
  - Edge k issues address A (rom_rd=1, ROM_addr=A).
  - Edge k+1: ROM samples A; t1<=A.
  - Edge k+2: t2 data captured into instr, instr_valid<=t2.valid, instr_pc<=t2.addr.
  - Fetch latency is 2 edges from issue to instr_valid; steady-state throughput is one instruction per cycle.
- Redirect condition: (PC_MUX==10 and branch_taken) or PC_MUX==11.
  - Branch target = redirect_pc + 1 + sign_extend(branch_offset), modulo 2^ADDR_W.
  - Jump target = jump_addr.
- FSM states:
  - BOOT: rom_rd=0 for exactly one cycle, then ROM_addr<=pc, rom_rd<=1, go to RUN. Redirect and stall are ignored in BOOT.
  - RUN, no stall, no redirect: ROM_addr<=ROM_addr+1, rom_rd=1, tags advance.
  - RUN, redirect:
    - ROM_addr<=target, rom_rd=1.
    - t1/t2 valid cleared, so both wrong-path fetches are squashed.
    - instr_valid<=0. instr_valid stays 0 for exactly 2 cycles, then target instruction appears.
  - RUN, stall=1 (no redirect):
    - instr, instr_valid, instr_pc and link_pc hold.
    - In-flight tags squashed; replay address = oldest valid tag addr (t2, else t1, else ROM_addr).
    - ROM_addr<=replay address, rom_rd<=0, go to STALL.
  - STALL, stall=1: hold everything, rom_rd=0.
  - STALL, stall=0: rom_rd<=1 at the replay address, go to RUN. The next valid instruction appears 2 edges later, with no gap in PC sequence.
  - Redirect in STALL: take the redirect as in RUN and go to RUN.
- Priority: reset > redirect > stall > sequential.
- Outputs while stalled: instr/instr_valid are not updated even if t2 is valid; that data is squashed and replayed.
- Wrap-around: PC 2^ADDR_W-1 followed by 0. Negative branch offsets wrap the same way.
- Reset mid-operation: all tags and outputs return to reset values immediately; the first fetch after reset release is RESET_PC.

Test Plan:
1. Boot: ROM M[i]=0x1000+i, release rst, no stall/redirect.
   -> rom_rd=0 for the first cycle.
   -> instr=0x1000, instr_pc=0, instr_valid=1 on the 3rd edge after release.
   -> Then 0x1001, 0x1002... every cycle, link_pc=instr_pc+1.
2. Taken beq: PC_MUX=10, branch_taken=1, redirect_pc=5, branch_offset=6'b111110 (-2).
   -> Target 4; instr_valid=0 for exactly 2 cycles.
   -> Next valid instr_pc=4, instr=0x1004.
3. Not-taken beq: PC_MUX=10, branch_taken=0 -> no bubble, instr_pc continues sequentially.
4. Jump: PC_MUX=11, jump_addr=0x800 -> after 2 invalid cycles instr_pc=0x800, instr=M[0x800].
5. Stall: assert stall 3 cycles while instr_pc=7 is presented.
   -> Outputs hold at 7, rom_rd=0 during STALL.
   -> After release, instr_pc=8 valid after 2 edges, then 9; no skipped or duplicated PCs.
   -> Stall+redirect in the same cycle: the redirect wins.
6. Wrap and reset: RESET_PC=0xFFE -> instr_pc sequence 0xFFE, 0xFFF, 0x000. Pulse rst low mid-stream -> all outputs reset asynchronously and fetch restarts at 0xFFE.

Source files
------------

// File: rtl/fetch_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fetch_unit_if                                                 |
// | Purpose  : Groups the signals that the fetch stage exchanges with the    |
// |            instruction ROM and with decode.                              |
// | Modports : master - fetch unit side (drives ROM request + instr out)     |
// |            slave  - environment side (ROM + decode/control)              |
// | Signals  : ROM_addr/rom_rd/ROM_data     synchronous ROM read port        |
// |            PC_MUX/branch_taken/redirect_pc/branch_offset/jump_addr       |
// |                                         redirect request from decode     |
// |            stall                        decode back-pressure             |
// |            instr/instr_valid/instr_pc/link_pc   fetched instruction      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface fetch_unit_if #(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned DATA_W = 16
) ();

   // ROM read port
   logic [ADDR_W-1:0] ROM_addr;
   logic              rom_rd;
   logic [DATA_W-1:0] ROM_data;

   // Redirect request
   logic [1:0]        PC_MUX;
   logic              branch_taken;
   logic [ADDR_W-1:0] redirect_pc;
   logic [5:0]        branch_offset;
   logic [ADDR_W-1:0] jump_addr;

   // Decode back-pressure
   logic              stall;

   // Fetched instruction towards decode
   logic [DATA_W-1:0] instr;
   logic              instr_valid;
   logic [ADDR_W-1:0] instr_pc;
   logic [ADDR_W-1:0] link_pc;

   modport master (
      output ROM_addr, rom_rd,
      input  ROM_data,
      input  PC_MUX, branch_taken, redirect_pc, branch_offset, jump_addr,
      input  stall,
      output instr, instr_valid, instr_pc, link_pc
   );

   modport slave (
      input  ROM_addr, rom_rd,
      output ROM_data,
      output PC_MUX, branch_taken, redirect_pc, branch_offset, jump_addr,
      output stall,
      input  instr, instr_valid, instr_pc, link_pc
   );

endinterface : fetch_unit_if
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fetch_unit                                                    |
// | Purpose  : Instruction fetch stage of the 16-bit myMIPS core. Owns the   |
// |            program counter, drives a synchronous instruction ROM, tracks |
// |            reads in flight and hands instructions to decode in order,    |
// |            applying branch/jump redirects and decode stalls without      |
// |            dropping or duplicating instructions.                         |
// | Ports    : clk  - rising-edge clock                                      |
// |            rst  - asynchronous, active-low reset                         |
// |            bus  - fetch_unit_if.master (ROM port, redirect, stall,       |
// |                   instr/instr_valid/instr_pc/link_pc)                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fetch_unit #(
   parameter int unsigned       ADDR_W   = 12,
   parameter int unsigned       DATA_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input wire           clk,
   input wire           rst,
   fetch_unit_if.master bus
);

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STALL = 2'd2
   } state_t;

   state_t            state_q,     state_d;

   // Issue stage: the address register doubles as the program counter.
   logic [ADDR_W-1:0] rom_addr_q,  rom_addr_d;
   logic              rom_rd_q,    rom_rd_d;

   // Tag of the word currently on ROM_data (address the ROM sampled).
   logic              t1_vld_q,    t1_vld_d;
   logic [ADDR_W-1:0] t1_addr_q,   t1_addr_d;

   // Output stage towards decode.
   logic [DATA_W-1:0] instr_q,     instr_d;
   logic              instr_vld_q, instr_vld_d;
   logic [ADDR_W-1:0] instr_pc_q,  instr_pc_d;
   logic [ADDR_W-1:0] link_pc_q,   link_pc_d;

   logic              redirect_w;
   logic [ADDR_W-1:0] br_target_w;
   logic [ADDR_W-1:0] target_w;
   logic [ADDR_W-1:0] replay_w;
   logic              deliver_w;

   // ------------------------------------------------------------------------
   // Redirect decode and target computation (all modulo 2^ADDR_W)
   // ------------------------------------------------------------------------
   assign redirect_w  = ((bus.PC_MUX == 2'b10) && bus.branch_taken) ||
                        (bus.PC_MUX == 2'b11);

   assign br_target_w = bus.redirect_pc + ADDR_W'(1) +
                        {{(ADDR_W-6){bus.branch_offset[5]}}, bus.branch_offset};

   assign target_w    = (bus.PC_MUX == 2'b11) ? bus.jump_addr : br_target_w;

   // Oldest instruction not yet handed to decode. The word on ROM_data is the
   // oldest in flight; otherwise the address being presented is, whether or
   // not it is being read this cycle.
   assign replay_w    = t1_vld_q ? t1_addr_q : rom_addr_q;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_BOOT;
         rom_addr_q  <= RESET_PC;
         rom_rd_q    <= 1'b0;
         t1_vld_q    <= 1'b0;
         t1_addr_q   <= '0;
         instr_q     <= '0;
         instr_vld_q <= 1'b0;
         instr_pc_q  <= '0;
         link_pc_q   <= ADDR_W'(1);
      end else begin
         state_q     <= state_d;
         rom_addr_q  <= rom_addr_d;
         rom_rd_q    <= rom_rd_d;
         t1_vld_q    <= t1_vld_d;
         t1_addr_q   <= t1_addr_d;
         instr_q     <= instr_d;
         instr_vld_q <= instr_vld_d;
         instr_pc_q  <= instr_pc_d;
         link_pc_q   <= link_pc_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and datapath control
   // ------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      rom_addr_d  = rom_addr_q;
      rom_rd_d    = rom_rd_q;
      // The ROM samples whatever is presented now; its tag follows it.
      t1_vld_d    = rom_rd_q;
      t1_addr_d   = rom_addr_q;
      instr_d     = instr_q;
      instr_vld_d = instr_vld_q;
      instr_pc_d  = instr_pc_q;
      link_pc_d   = link_pc_q;
      deliver_w   = 1'b0;

      unique case (state_q)
         ST_BOOT: begin
            // One idle cycle after reset, then start at the reset vector.
            rom_addr_d = RESET_PC;
            rom_rd_d   = 1'b1;
            state_d    = ST_RUN;
         end

         ST_RUN, ST_STALL: begin
            if (redirect_w) begin
               // Both wrong-path words (on ROM_data and being sampled now)
               // are discarded by clearing their tags.
               rom_addr_d  = target_w;
               rom_rd_d    = 1'b1;
               t1_vld_d    = 1'b0;
               instr_vld_d = 1'b0;
               state_d     = ST_RUN;
            end else if (bus.stall) begin
               // Outputs hold. Everything in flight is dropped and will be
               // re-read from the oldest undelivered address on release.
               t1_vld_d   = 1'b0;
               rom_addr_d = replay_w;
               rom_rd_d   = 1'b0;
               state_d    = ST_STALL;
            end else begin
               deliver_w = 1'b1;
               rom_rd_d  = 1'b1;
               state_d   = ST_RUN;
               // Leaving STALL re-issues the replay address as-is.
               if (state_q == ST_RUN) begin
                  rom_addr_d = rom_addr_q + ADDR_W'(1);
               end
            end
         end

         default: begin
            state_d  = ST_BOOT;
            rom_rd_d = 1'b0;
         end
      endcase

      // Decode consumed (or never had) the current instruction: present the
      // word on ROM_data if its tag is live. Dead words leave the payload
      // untouched so instr/instr_pc only ever show real fetches.
      if (deliver_w) begin
         instr_vld_d = t1_vld_q;
         if (t1_vld_q) begin
            instr_d    = bus.ROM_data;
            instr_pc_d = t1_addr_q;
            link_pc_d  = t1_addr_q + ADDR_W'(1);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign bus.ROM_addr    = rom_addr_q;
   assign bus.rom_rd      = rom_rd_q;
   assign bus.instr       = instr_q;
   assign bus.instr_valid = instr_vld_q;
   assign bus.instr_pc    = instr_pc_q;
   assign bus.link_pc     = link_pc_q;

endmodule : fetch_unit
`default_nettype wire
